// File: rtl/spi_pkg.sv
// Shared SPI register map: addresses, STATUS/CTRL bit positions and mode encodings.
// Used by both spi_slave and spi_master.
package spi_pkg;

   localparam logic [3:0] ADDR_STATUS   = 4'h0;
   localparam logic [3:0] ADDR_DATA_OUT = 4'h1;
   localparam logic [3:0] ADDR_DATA_IN  = 4'h2;
   localparam logic [3:0] ADDR_CTRL     = 4'h3;

   localparam int CTRL_CPHA   = 0;
   localparam int CTRL_CPOL   = 1;
   localparam int CTRL_EN     = 2;
   localparam int CTRL_INT_EN = 3;

   localparam int STAT_BUSY     = 0;
   localparam int STAT_RX_FULL  = 1;
   localparam int STAT_OVERRUN  = 2;
   localparam int STAT_TX_EMPTY = 3;

   typedef enum logic [1:0] {
      MODE0 = 2'd0,
      MODE1 = 2'd1,
      MODE2 = 2'd2,
      MODE3 = 2'd3
   } spi_mode_e;

endpackage

// File: rtl/spi_slave_if.sv
// CPU register port of the SPI peripherals: strobe, direction, address, data and interrupt.
interface spi_slave_if;

   logic       i_en;
   logic       i_wr;
   logic [3:0] i_addr;
   logic [7:0] i_data;
   logic [7:0] o_data;
   logic       o_int;

   modport slave (
      input  i_en, i_wr, i_addr, i_data,
      output o_data, o_int
   );

   modport master (
      output i_en, i_wr, i_addr, i_data,
      input  o_data, o_int
   );

endinterface

// File: rtl/spi_sync.sv
// N-flop synchronizer for an asynchronous input, with a selectable reset level.
module spi_sync #(
   parameter int   STAGES  = 2,
   parameter logic RST_VAL = 1'b0
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_d,
   output logic o_q
);

   logic [STAGES-1:0] sync_q;
   logic [STAGES-1:0] sync_d;

   always_comb begin
      sync_d = {sync_q[STAGES-2:0], i_d};
   end

   // NOTE: state is written with <= so every flop samples pre-edge values; = here would collapse the chain.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) sync_q <= {STAGES{RST_VAL}};
      else          sync_q <= sync_d;
   end

   assign o_q = sync_q[STAGES-1];

endmodule

// File: rtl/spi_slave.sv
// SPI sub peripheral: synchronizes the external SCLK/SS_bar/MOSI into i_clk, shifts
// MSB-first in all four modes and exposes a byte-wide CPU register port with an interrupt.
module spi_slave
   import spi_pkg::*;
#(
   parameter int         CLK_FREQ    = 48_000_000,
   parameter int         SYNC_STAGES = 2,
   parameter logic [7:0] TX_IDLE     = 8'hFF
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_SCLK,
   input  logic        i_SS_bar,
   input  logic        i_MOSI,
   output logic        o_MISO,
   output logic        o_MISO_oe,
   spi_slave_if.slave  bus
);

   if (SYNC_STAGES < 2 || CLK_FREQ < 8) begin : g_cfg_check
      $error("spi_slave: SYNC_STAGES must be >= 2 and CLK_FREQ >= 8");
   end

   logic sclk_s, ss_bar_s, mosi_s;

   spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_d(i_SCLK), .o_q(sclk_s));
   spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ss (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_d(i_SS_bar), .o_q(ss_bar_s));
   spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_d(i_MOSI), .o_q(mosi_s));

   logic       sclk_prev_q, sclk_prev_d;
   logic       ss_prev_q, ss_prev_d;
   logic [3:0] ctrl_q, ctrl_d;
   spi_mode_e  mode_q, mode_d;
   logic       xfer_q, xfer_d;
   logic [2:0] bit_cnt_q, bit_cnt_d;
   logic [7:0] tx_shift_q, tx_shift_d;
   logic [7:0] rx_shift_q, rx_shift_d;
   logic [7:0] rx_reg_q, rx_reg_d;
   logic       rx_full_q, rx_full_d;
   logic       overrun_q, overrun_d;
   logic [7:0] tx_hold_q, tx_hold_d;
   logic       tx_empty_q, tx_empty_d;
   logic [7:0] rdata_q, rdata_d;
   logic       int_q, int_d;

   logic ss_fall, ss_rise, sclk_rise, sclk_fall, leading, trailing;
   logic active, sample, shift, byte_done, select_start, reload;
   logic rd, wr, rd_data_in, ovr_set, busy;
   logic [7:0] rx_byte;

   always_comb begin
      ss_fall   = ss_prev_q & ~ss_bar_s;
      ss_rise   = ~ss_prev_q & ss_bar_s;
      sclk_rise = ~sclk_prev_q & sclk_s;
      sclk_fall = sclk_prev_q & ~sclk_s;
      leading   = mode_q[CTRL_CPOL] ? sclk_fall : sclk_rise;
      trailing  = mode_q[CTRL_CPOL] ? sclk_rise : sclk_fall;

      active       = xfer_q & ctrl_q[CTRL_EN] & ~ss_bar_s;
      sample       = active & (mode_q[CTRL_CPHA] ? trailing : leading);
      // The first shift edge of a byte is skipped: its MSB is already on MISO from the load.
      shift        = active & (bit_cnt_q != 3'd0) & (mode_q[CTRL_CPHA] ? leading : trailing);
      byte_done    = sample & (bit_cnt_q == 3'd7);
      select_start = ss_fall & ctrl_q[CTRL_EN];
      reload       = select_start | byte_done;
      rx_byte      = {rx_shift_q[6:0], mosi_s};

      rd         = bus.i_en & ~bus.i_wr;
      wr         = bus.i_en & bus.i_wr;
      rd_data_in = rd & (bus.i_addr == ADDR_DATA_IN);
      busy       = ~ss_bar_s & (bit_cnt_q != 3'd0);
   end

   always_comb begin
      // NOTE: every always_comb output takes a default first so no path can infer a latch.
      sclk_prev_d = sclk_s;
      ss_prev_d   = ss_bar_s;
      ctrl_d      = ctrl_q;
      mode_d      = mode_q;
      xfer_d      = xfer_q;
      bit_cnt_d   = bit_cnt_q;
      tx_shift_d  = tx_shift_q;
      rx_shift_d  = rx_shift_q;
      rx_reg_d    = rx_reg_q;
      rx_full_d   = rx_full_q;
      overrun_d   = overrun_q;
      tx_hold_d   = tx_hold_q;
      tx_empty_d  = tx_empty_q;
      rdata_d     = rdata_q;
      ovr_set     = 1'b0;
      int_d       = byte_done & ctrl_q[CTRL_INT_EN];

      if (ss_rise) begin
         xfer_d    = 1'b0;
         bit_cnt_d = 3'd0;
      end
      if (select_start) begin
         xfer_d    = 1'b1;
         mode_d    = spi_mode_e'(ctrl_q[1:0]);
         bit_cnt_d = 3'd0;
      end
      if (sample) begin
         rx_shift_d = rx_byte;
         bit_cnt_d  = bit_cnt_q + 3'd1;
      end
      if (shift) tx_shift_d = {tx_shift_q[6:0], 1'b0};

      // Read side effects come first so a coincident byte completion wins.
      if (rd && bus.i_addr == ADDR_STATUS) overrun_d = 1'b0;
      if (rd_data_in)                      rx_full_d = 1'b0;

      if (byte_done) begin
         if (!rx_full_q || rd_data_in) begin
            rx_reg_d  = rx_byte;
            rx_full_d = 1'b1;
         end else begin
            ovr_set   = 1'b1;
            overrun_d = 1'b1;
         end
      end

      if (reload) begin
         tx_shift_d = tx_empty_q ? TX_IDLE : tx_hold_q;
         tx_empty_d = 1'b1;
      end

      if (wr) begin
         case (bus.i_addr)
            ADDR_DATA_OUT: begin
               tx_hold_d  = bus.i_data;
               tx_empty_d = 1'b0;
            end
            ADDR_CTRL: ctrl_d = bus.i_data[3:0];
            default: ;
         endcase
      end

      if (rd) begin
         case (bus.i_addr)
            ADDR_STATUS:  rdata_d = {4'b0, tx_empty_q, overrun_q | ovr_set, rx_full_q, busy};
            ADDR_DATA_IN: rdata_d = rx_reg_q;
            ADDR_CTRL:    rdata_d = {4'b0, ctrl_q};
            default:      rdata_d = 8'h00;
         endcase
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         sclk_prev_q <= 1'b0;
         ss_prev_q   <= 1'b1;
         ctrl_q      <= 4'h0;
         mode_q      <= MODE0;
         xfer_q      <= 1'b0;
         bit_cnt_q   <= 3'd0;
         tx_shift_q  <= 8'h00;
         rx_shift_q  <= 8'h00;
         rx_reg_q    <= 8'h00;
         rx_full_q   <= 1'b0;
         overrun_q   <= 1'b0;
         tx_hold_q   <= 8'h00;
         tx_empty_q  <= 1'b1;
         rdata_q     <= 8'h00;
         int_q       <= 1'b0;
      end else begin
         sclk_prev_q <= sclk_prev_d;
         ss_prev_q   <= ss_prev_d;
         ctrl_q      <= ctrl_d;
         mode_q      <= mode_d;
         xfer_q      <= xfer_d;
         bit_cnt_q   <= bit_cnt_d;
         tx_shift_q  <= tx_shift_d;
         rx_shift_q  <= rx_shift_d;
         rx_reg_q    <= rx_reg_d;
         rx_full_q   <= rx_full_d;
         overrun_q   <= overrun_d;
         tx_hold_q   <= tx_hold_d;
         tx_empty_q  <= tx_empty_d;
         rdata_q     <= rdata_d;
         int_q       <= int_d;
      end
   end

   assign o_MISO     = tx_shift_q[7];
   assign o_MISO_oe  = ctrl_q[CTRL_EN] & ~ss_bar_s;
   assign bus.o_data = rdata_q;
   assign bus.o_int  = int_q;

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: drives an SPI master model and the CPU register port.
module tb_spi_slave;

   localparam int HALF = 8;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic sclk = 1'b0;
   logic ss_bar = 1'b1;
   logic mosi = 1'b0;
   logic miso, miso_oe;

   int checks = 0;
   int failures = 0;
   int int_cnt = 0;

   spi_slave_if bus_if ();

   spi_slave dut (
      .i_clk    (clk),
      .i_rst_n  (rst_n),
      .i_SCLK   (sclk),
      .i_SS_bar (ss_bar),
      .i_MOSI   (mosi),
      .o_MISO   (miso),
      .o_MISO_oe(miso_oe),
      .bus      (bus_if.slave)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (bus_if.o_int) int_cnt++;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic cpu_write(input logic [3:0] addr, input logic [7:0] data);
      @(negedge clk);
      bus_if.i_en = 1'b1; bus_if.i_wr = 1'b1; bus_if.i_addr = addr; bus_if.i_data = data;
      @(negedge clk);
      bus_if.i_en = 1'b0; bus_if.i_wr = 1'b0;
   endtask

   task automatic cpu_read(input logic [3:0] addr, output logic [7:0] data);
      @(negedge clk);
      bus_if.i_en = 1'b1; bus_if.i_wr = 1'b0; bus_if.i_addr = addr;
      @(negedge clk);
      bus_if.i_en = 1'b0;
      data = bus_if.o_data;
   endtask

   task automatic wait_half();
      repeat (HALF) @(posedge clk);
      #1;
   endtask

   task automatic ss_low();
      ss_bar = 1'b0;
      wait_half();
   endtask

   task automatic ss_high();
      wait_half();
      ss_bar = 1'b1;
      wait_half();
   endtask

   // Master side of one transfer: sends the top nbits of tx, returns what MISO carried.
   task automatic xfer(input logic [1:0] mode, input logic [7:0] tx, input int nbits,
                       output logic [7:0] rx);
      logic cpol, cpha;
      cpol = mode[1];
      cpha = mode[0];
      rx = 8'h00;
      for (int i = 7; i > 7 - nbits; i--) begin
         if (!cpha) begin
            mosi = tx[i];
            wait_half();
            sclk = ~cpol;
            rx[i] = miso;
            wait_half();
            sclk = cpol;
         end else begin
            wait_half();
            sclk = ~cpol;
            mosi = tx[i];
            wait_half();
            sclk = cpol;
            rx[i] = miso;
         end
      end
   endtask

   initial begin
      logic [7:0] rd, rx;
      bus_if.i_en = 1'b0; bus_if.i_wr = 1'b0; bus_if.i_addr = 4'h0; bus_if.i_data = 8'h00;
      repeat (3) @(negedge clk);
      check("reset_o_data", bus_if.o_data, 8'h00);
      check("reset_o_int", bus_if.o_int, 1'b0);
      check("reset_miso", miso, 1'b0);
      check("reset_miso_oe", miso_oe, 1'b0);
      rst_n = 1'b1;
      cpu_read(4'h0, rd);
      check("reset_status", rd, 8'h08);

      // Mode 0 exchange with a loaded DATA_OUT.
      cpu_write(4'h3, 8'h0C);
      cpu_write(4'h1, 8'h3C);
      cpu_read(4'h0, rd);
      check("t1_status_tx_loaded", rd, 8'h00);
      ss_low();
      xfer(2'd0, 8'hA5, 8, rx);
      ss_high();
      check("t1_master_rx", rx, 8'h3C);
      check("t1_int_count", int_cnt, 1);
      cpu_read(4'h0, rd);
      check("t1_status", rd, 8'h0A);
      cpu_read(4'h2, rd);
      check("t1_data_in", rd, 8'hA5);
      cpu_read(4'h0, rd);
      check("t1_status_cleared", rd, 8'h08);

      // Mode 3 with nothing loaded: idle byte goes out.
      cpu_write(4'h3, 8'h0F);
      sclk = 1'b1;
      wait_half();
      check("t2_oe_before_ss", miso_oe, 1'b0);
      ss_low();
      check("t2_oe_during_ss", miso_oe, 1'b1);
      xfer(2'd3, 8'h81, 8, rx);
      ss_high();
      check("t2_oe_after_ss", miso_oe, 1'b0);
      check("t2_master_rx", rx, 8'hFF);
      cpu_read(4'h2, rd);
      check("t2_data_in", rd, 8'h81);
      check("t2_int_count", int_cnt, 2);

      // Back-to-back bytes without draining DATA_IN.
      cpu_write(4'h3, 8'h0C);
      sclk = 1'b0;
      wait_half();
      ss_low();
      xfer(2'd0, 8'h11, 8, rx);
      xfer(2'd0, 8'h22, 8, rx);
      ss_high();
      check("t3_second_rx", rx, 8'hFF);
      cpu_read(4'h0, rd);
      check("t3_status_overrun", rd, 8'h0E);
      cpu_read(4'h0, rd);
      check("t3_status_ovr_cleared", rd, 8'h0A);
      cpu_read(4'h2, rd);
      check("t3_data_in", rd, 8'h11);
      check("t3_int_count", int_cnt, 4);

      // Select released after five bits.
      ss_low();
      xfer(2'd0, 8'hF7, 5, rx);
      wait_half();
      cpu_read(4'h0, rd);
      check("t4_status_busy", rd, 8'h09);
      ss_high();
      cpu_read(4'h0, rd);
      check("t4_status_aborted", rd, 8'h08);
      check("t4_int_count", int_cnt, 4);
      ss_low();
      xfer(2'd0, 8'h5A, 8, rx);
      ss_high();
      cpu_read(4'h2, rd);
      check("t4_data_in", rd, 8'h5A);
      check("t4_int_count_after", int_cnt, 5);

      // Reset asserted in the middle of a mode 1 byte.
      cpu_write(4'h3, 8'h0D);
      cpu_write(4'h1, 8'hF0);
      ss_low();
      xfer(2'd1, 8'hC3, 4, rx);
      repeat (5) @(negedge clk);
      cpu_read(4'h3, rd);
      check("t5_ctrl_before_reset", rd, 8'h0D);
      check("t5_miso_before_reset", miso, 1'b1);
      check("t5_oe_before_reset", miso_oe, 1'b1);
      #1 rst_n = 1'b0;
      #1;
      check("t5_rst_miso", miso, 1'b0);
      check("t5_rst_oe", miso_oe, 1'b0);
      check("t5_rst_o_data", bus_if.o_data, 8'h00);
      check("t5_rst_o_int", bus_if.o_int, 1'b0);
      ss_bar = 1'b1;
      repeat (4) @(negedge clk);
      rst_n = 1'b1;
      cpu_read(4'h0, rd);
      check("t5_status_after_reset", rd, 8'h08);
      cpu_write(4'h3, 8'h0D);
      ss_low();
      xfer(2'd1, 8'hC3, 8, rx);
      ss_high();
      check("t5_master_rx", rx, 8'hFF);
      cpu_read(4'h2, rd);
      check("t5_data_in", rd, 8'hC3);
      check("t5_int_count", int_cnt, 6);

      // Register-port corner cases.
      cpu_read(4'h3, rd);
      repeat (3) @(negedge clk);
      check("t6_o_data_holds", bus_if.o_data, 8'h0D);
      cpu_read(4'h7, rd);
      check("t6_unmapped_read", rd, 8'h00);
      cpu_read(4'h1, rd);
      check("t6_data_out_read", rd, 8'h00);
      cpu_write(4'h2, 8'h77);
      cpu_read(4'h2, rd);
      check("t6_data_in_write_ignored", rd, 8'hC3);
      cpu_write(4'h3, 8'hFF);
      cpu_read(4'h3, rd);
      check("t6_ctrl_readback", rd, 8'h0F);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
